// File: rtl/cnn_pkg.sv
// Shared types and the requantisation helper for the CNN-to-FC feeder stages.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package cnn_pkg;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } loader_state_t;

    // Working width for requantisation; wide enough for any accumulator used upstream.
    localparam int REQ_W = 64;

    // Arithmetic shift, then clamp to the unsigned (relu) or signed range of a dw-bit word.
    // Callers pass elaboration-time constants for shift/relu_en/dw, so this reduces to a
    // fixed shifter plus two comparators.
    function automatic logic signed [REQ_W-1:0] sat_requant(
        input logic signed [REQ_W-1:0] acc,
        input int                      shift,
        input int                      relu_en,
        input int                      dw
    );
        logic signed [REQ_W-1:0] t;
        logic signed [REQ_W-1:0] lo;
        logic signed [REQ_W-1:0] hi;
        t = acc >>> shift;
        if (relu_en != 0) begin
            lo = '0;
            hi = (64'sd1 <<< dw) - 64'sd1;
        end else begin
            lo = -(64'sd1 <<< (dw - 1));
            hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        end
        if (t < lo) begin
            return lo;
        end else if (t > hi) begin
            return hi;
        end
        return t;
    endfunction

endpackage

// File: rtl/cnn_flatten_loader_requant_sat.sv
// Requantise one signed accumulator beat: arithmetic shift, optional ReLU, saturate.
// Latency: purely combinational.
// Backpressure: none; follows its input.
module requant_sat
    import cnn_pkg::*;
#(
    parameter int acc_size      = 24,
    parameter int datatype_size = 8,
    parameter int shift         = 8,
    parameter int relu_en       = 1
) (
    input  logic signed [acc_size-1:0]      acc,
    output logic        [datatype_size-1:0] q
);

    logic signed [REQ_W-1:0] acc_ext;

    // Sign-extend explicitly so the shift below is arithmetic on the true value.
    assign acc_ext = {{(REQ_W - acc_size){acc[acc_size-1]}}, acc};

    // Clamped result always fits in datatype_size bits (two's complement when signed).
    assign q = datatype_size'(sat_requant(acc_ext, shift, relu_en, datatype_size));

endmodule

// File: rtl/cnn_flatten_loader.sv
// Requantise the conv accumulator stream into the FC input buffer, then pulse start.
// Latency: ibuf write one cycle after each accepted beat; start at earliest the cycle after the last accept.
// Backpressure: o_ready only in FILL; held low from frame end until the layer has taken and released the buffer.
module cnn_flatten_loader
    import cnn_pkg::*;
#(
    parameter int input_size    = 201,
    parameter int acc_size      = 24,
    parameter int datatype_size = 8,
    parameter int shift         = 8,
    parameter int relu_en       = 1,
    localparam int AW           = (input_size > 1) ? $clog2(input_size) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_valid,
    input  logic signed [acc_size-1:0]      i_data,
    output logic                            o_ready,
    output logic                            o_ibuf_we,
    output logic        [AW-1:0]            o_ibuf_addr,
    output logic        [datatype_size-1:0] o_ibuf_wr_data,
    output logic                            o_start,
    input  logic                            i_layer_busy,
    output logic                            o_busy
);

    localparam logic [AW-1:0] LAST = AW'(input_size - 1);

    loader_state_t            state;
    loader_state_t            state_nxt;
    logic [AW-1:0]            count;
    logic                     accept;
    logic                     last_beat;
    logic [datatype_size-1:0] q;

    assign accept    = i_valid && o_ready;
    assign last_beat = (count == LAST);

    requant_sat #(
        .acc_size      (acc_size),
        .datatype_size (datatype_size),
        .shift         (shift),
        .relu_en       (relu_en)
    ) u_requant (
        .acc (i_data),
        .q   (q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame handshake: fill, fire start when the layer is idle, then wait for it to take and release the buffer.
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:      if (accept && last_beat) state_nxt = LAUNCH;
            LAUNCH:    if (!i_layer_busy)       state_nxt = WAIT_ACK;
            WAIT_ACK:  if (i_layer_busy)        state_nxt = WAIT_DONE;
            WAIT_DONE: if (!i_layer_busy)       state_nxt = FILL;
            default:                            state_nxt = FILL;
        endcase
    end

    // Handshake outputs; ready and start are masked while reset is asserted.
    always_comb begin
        o_ready = (state == FILL) && !rst;
        o_start = (state == LAUNCH) && !i_layer_busy && !rst;
        o_busy  = !((state == FILL) && (count == '0));
    end

    // Write counter and registered ibuf port; addr/data hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            count          <= '0;
            o_ibuf_we      <= 1'b0;
            o_ibuf_addr    <= '0;
            o_ibuf_wr_data <= '0;
        end else begin
            o_ibuf_we <= accept;
            if (accept) begin
                o_ibuf_addr    <= count;
                o_ibuf_wr_data <= q;
                count          <= last_beat ? '0 : count + AW'(1);
            end
        end
    end

endmodule

// File: tb/tb_cnn_flatten_loader.sv
// Bench for cnn_flatten_loader: random/directed frames checked against a behavioural model.
// Latency: model expects each write one cycle after accept and start on the first idle-layer cycle after frame end.
// Backpressure: driver holds each beat until accepted; a layer model answers each start with a busy window.
`timescale 1ns/1ps
module tb_cnn_flatten_loader;

    localparam int N = 201;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [23:0] i_data = '0;
    logic        i_layer_busy = 1'b0;
    logic        o_ready;
    logic        o_ibuf_we;
    logic [7:0]  o_ibuf_addr;
    logic [7:0]  o_ibuf_wr_data;
    logic        o_start;
    logic        o_busy;

    // Second build: single-entry vector, signed clamp.
    logic        v2 = 1'b0;
    logic [23:0] d2 = '0;
    logic        busy2 = 1'b0;
    logic        rdy2;
    logic        we2;
    logic [0:0]  addr2;
    logic [7:0]  wd2;
    logic        start2;
    logic        obusy2;

    cnn_flatten_loader #(
        .input_size(N), .acc_size(24), .datatype_size(8), .shift(8), .relu_en(1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .i_data         (i_data),
        .o_ready        (o_ready),
        .o_ibuf_we      (o_ibuf_we),
        .o_ibuf_addr    (o_ibuf_addr),
        .o_ibuf_wr_data (o_ibuf_wr_data),
        .o_start        (o_start),
        .i_layer_busy   (i_layer_busy),
        .o_busy         (o_busy)
    );

    cnn_flatten_loader #(
        .input_size(1), .acc_size(24), .datatype_size(8), .shift(8), .relu_en(0)
    ) dut2 (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (v2),
        .i_data         (d2),
        .o_ready        (rdy2),
        .o_ibuf_we      (we2),
        .o_ibuf_addr    (addr2),
        .o_ibuf_wr_data (wd2),
        .o_start        (start2),
        .i_layer_busy   (busy2),
        .o_busy         (obusy2)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference requantisation: floor(v / 256), then clamp to the output range.
    function automatic logic [7:0] ref_q(input logic [23:0] d, input bit relu);
        int v, t, lo, hi;
        v = int'($signed(d));
        if (v >= 0) t = v / 256;
        else        t = -((-v + 255) / 256);
        lo = relu ? 0 : -128;
        hi = relu ? 255 : 127;
        if (t < lo) t = lo;
        if (t > hi) t = hi;
        return 8'(t);
    endfunction

    // ---------------- behavioural model + monitor (main DUT) ----------------
    // ph: 0 collecting beats, 1 frame done / start owed, 2 start given, 3 layer has the buffer
    int   ph = 0;
    int   mcnt = 0;
    bit   prev_acc = 1'b0;
    int   q_addr[$];
    int   q_data[$];
    int   dut_acc_cnt = 0;
    int   wr_cnt = 0;
    int   dut_start_cnt = 0;
    bit   chk_we_busy = 1'b0;
    logic [7:0] last_wr [0:255];

    always @(negedge clk) begin : mon
        bit exp_rdy;
        bit exp_start;
        bit acc;
        exp_rdy   = !rst && (ph == 0);
        exp_start = !rst && (ph == 1) && !i_layer_busy;
        check_eq("ready", o_ready, exp_rdy);
        check_eq("start", o_start, exp_start);
        check_eq("busy", o_busy, !(ph == 0 && mcnt == 0));
        check_eq("we_lat", o_ibuf_we, prev_acc);
        if (o_ibuf_we) begin
            if (q_addr.size() == 0) begin
                check_eq("wr_unexpected", q_addr.size(), 1);
            end else begin
                check_eq("wr_addr", o_ibuf_addr, q_addr.pop_front());
                check_eq("wr_data", o_ibuf_wr_data, q_data.pop_front());
            end
            last_wr[o_ibuf_addr] = o_ibuf_wr_data;
            wr_cnt++;
        end
        if (chk_we_busy) check_eq("we_busy", o_ibuf_we && i_layer_busy, 0);
        if (o_start) dut_start_cnt++;
        if (i_valid && o_ready) dut_acc_cnt++;
        if (rst) begin
            ph = 0; mcnt = 0; prev_acc = 0;
            q_addr.delete(); q_data.delete();
        end else begin
            acc = i_valid && (ph == 0);
            prev_acc = acc;
            if (acc) begin
                q_addr.push_back(mcnt);
                q_data.push_back(int'(ref_q(i_data, 1'b1)));
                if (mcnt == N - 1) begin mcnt = 0; ph = 1; end
                else mcnt++;
            end else begin
                case (ph)
                    1: if (!i_layer_busy) ph = 2;
                    2: if (i_layer_busy)  ph = 3;
                    3: if (!i_layer_busy) ph = 0;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- layer model: busy window after each start ----------------
    int layer_len = 20;
    bit force_busy = 1'b0;
    int seen_starts = 0;
    int remain = 0;

    always @(posedge clk) begin
        #2;
        if (remain > 0) remain--;
        if (dut_start_cnt != seen_starts) begin
            seen_starts = dut_start_cnt;
            remain = layer_len;
        end
        i_layer_busy = force_busy || (remain > 0);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_beat(input logic [23:0] d, input int gap);
        int guard;
        i_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        i_valid = 1'b1;
        i_data  = d;
        guard   = 0;
        forever begin
            @(negedge clk);
            if (o_ready) begin @(posedge clk); #1; break; end
            @(posedge clk); #1;
            guard++;
            if (guard > 3000) begin check_eq("accept_timeout", guard, 0); break; end
        end
        i_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int guard;
        guard = 0;
        while (!(o_ready && !i_layer_busy) && guard < 3000) begin @(posedge clk); #1; guard++; end
        check_eq(tag, guard < 3000, 1);
    endtask

    task automatic run2(input logic [23:0] d, input logic [7:0] exp, input string tag);
        v2 = 1'b1; d2 = d;
        @(negedge clk); check_eq({tag, "_rdy"}, rdy2, 1);
        @(posedge clk); #1; v2 = 1'b0;
        @(negedge clk);
        check_eq({tag, "_we"}, we2, 1);
        check_eq({tag, "_addr"}, addr2, 0);
        check_eq({tag, "_data"}, wd2, exp);
        check_eq({tag, "_start"}, start2, 1);
        check_eq({tag, "_rdy_lo"}, rdy2, 0);
        @(posedge clk); #1; busy2 = 1'b1;
        @(negedge clk);
        check_eq({tag, "_start_once"}, start2, 0);
        check_eq({tag, "_obusy"}, obusy2, 1);
        @(posedge clk); #1; busy2 = 1'b0;
        @(negedge clk); check_eq({tag, "_rdy_wait"}, rdy2, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq({tag, "_rdy_back"}, rdy2, 1);
        check_eq({tag, "_we_lo"}, we2, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int a0, w0, s0;
        logic [23:0] d;
        logic [23:0] r;

        rst = 1'b1;
        wait_cycles(3);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_ready", o_ready, 1);
        check_eq("rst_we", o_ibuf_we, 0);
        check_eq("rst_addr", o_ibuf_addr, 0);
        check_eq("rst_data", o_ibuf_wr_data, 0);
        check_eq("rst_start", o_start, 0);
        check_eq("rst_busy", o_busy, 0);
        @(posedge clk); #1;

        // Frame A: back-to-back ramp k<<8 -> data k
        a0 = dut_acc_cnt; w0 = wr_cnt; s0 = dut_start_cnt;
        for (int k = 0; k < N; k++) send_beat(24'(k << 8), 0);
        wait_cycles(3);
        check_eq("A_accepts", dut_acc_cnt - a0, N);
        check_eq("A_writes", wr_cnt - w0, N);
        check_eq("A_starts", dut_start_cnt - s0, 1);
        check_eq("A_addr0", last_wr[0], 0);
        check_eq("A_addr137", last_wr[137], 137);
        check_eq("A_addr200", last_wr[200], 200);
        wait_ready("A_release");

        // Frame B: 50% valid gaps, ReLU extremes, layer held busy across frame end
        a0 = dut_acc_cnt; w0 = wr_cnt; s0 = dut_start_cnt;
        for (int k = 0; k < N; k++) begin
            if (k == 0)      d = 24'hFFEC78;
            else if (k == 1) d = 24'h7FFFFF;
            else             d = 24'($urandom);
            if (k == 195) force_busy = 1'b1;
            send_beat(d, int'($urandom_range(0, 1)));
        end
        wait_cycles(30);
        check_eq("B_start_held", dut_start_cnt - s0, 0);
        @(negedge clk); check_eq("B_ready_held", o_ready, 0);
        @(posedge clk); #1;
        force_busy = 1'b0;
        wait_cycles(3);
        check_eq("B_starts", dut_start_cnt - s0, 1);
        check_eq("B_accepts", dut_acc_cnt - a0, N);
        check_eq("B_writes", wr_cnt - w0, N);
        check_eq("B_relu_neg", last_wr[0], 0);
        check_eq("B_relu_pos", last_wr[1], 255);
        wait_ready("B_release");

        // Frame C aborted by reset after 100 beats, then full frame D
        s0 = dut_start_cnt;
        for (int k = 0; k < 100; k++) send_beat(24'($urandom), 0);
        rst = 1'b1;
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(2);
        check_eq("C_no_start", dut_start_cnt - s0, 0);
        check_eq("C_busy_clear", o_busy, 0);
        w0 = wr_cnt;
        for (int k = 0; k < N; k++) send_beat(24'($urandom), 0);
        wait_cycles(3);
        check_eq("D_writes", wr_cnt - w0, N);
        check_eq("D_starts", dut_start_cnt - s0, 1);
        wait_ready("D_release");

        // Frames E,F: long layer busy; no writes while the layer owns the buffer
        layer_len = 300;
        chk_we_busy = 1'b1;
        s0 = dut_start_cnt; w0 = wr_cnt;
        for (int f = 0; f < 2; f++)
            for (int k = 0; k < N; k++) send_beat(24'($urandom), int'($urandom_range(0, 1)));
        wait_cycles(3);
        check_eq("EF_starts", dut_start_cnt - s0, 2);
        check_eq("EF_writes", wr_cnt - w0, 2 * N);
        wait_ready("EF_release");
        chk_we_busy = 1'b0;
        layer_len = 20;

        // Signed-clamp, single-entry build
        run2(24'hFFEC78, 8'hEC, "S_neg");
        run2(24'h7FFFFF, 8'h7F, "S_pos");
        r = 24'($urandom);
        run2(r, ref_q(r, 1'b0), "S_rand");
        r = 24'h800000;
        run2(r, 8'h80, "S_min");

        wait_cycles(5);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
